lv2_miss_fill_ctrl: RTL and testbench
=====================================

LV2_MISS_FILL_CTRL -- requirements
Module: lv2_miss_fill_ctrl

Interface
REQ-001 SHALL have parameter ASSOC, default `ASSOC_LV2, L2 associativity.
REQ-002 SHALL have parameter ASSOC_WID, default `ASSOC_WID_LV2, way-index width.
REQ-003 SHALL have parameter ADDR_WID, default 32, block address width.
REQ-004 SHALL have parameter TIMEOUT, default 255, max wait cycles in WB or RD (range 1..255).
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port miss_req  input  1  L2 pipeline requests miss service; held until miss_ack.
REQ-008 SHALL have port miss_addr  input  ADDR_WID  missing block address.
REQ-009 SHALL have port victim_way  input  ASSOC_WID  way chosen by block-selection logic (hit/free/LRU).
REQ-010 SHALL have port victim_valid, victim_dirty  input  1 each  victim way status.
REQ-011 SHALL have port victim_addr  input  ADDR_WID  address of victim block.
REQ-012 SHALL have port miss_ack  output  1  one-cycle capture pulse.
REQ-013 SHALL have port wb_req  output  1; wb_addr  output  ADDR_WID; wb_way  output  ASSOC_WID; wb_done  input  1.
REQ-014 SHALL have port mem_rd_req  output  1; mem_rd_addr  output  ADDR_WID; mem_rd_done  input  1.
REQ-015 SHALL have port fill_en  output  1; fill_way  output  ASSOC_WID; fill_addr  output  ADDR_WID.
REQ-016 SHALL have port lru_update  output  1  pulse marking fill_way most-recent.
REQ-017 SHALL have port busy  output  1; timeout_err  output  1 sticky error.

Function
REQ-018 SHALL implement FSM states IDLE, WB, RD, FILL; all outputs registered.
REQ-019 SHALL capture miss_addr, victim_way, victim_addr, victim_valid&victim_dirty in cycle T when state=IDLE and miss_req=1.
REQ-020 SHALL, at T+1, enter WB if captured valid&dirty, else RD; miss_ack=1 during T+1 only.
REQ-021 SHALL ignore miss_req whenever state!=IDLE; no second capture from a still-held request in the ack cycle.
REQ-022 SHALL hold wb_req=1 with wb_addr=victim_addr, wb_way=victim_way for every WB cycle; wb_done=1 in any WB cycle (including first) moves to RD next cycle.
REQ-023 SHALL hold mem_rd_req=1 with mem_rd_addr=captured miss_addr for every RD cycle; mem_rd_done=1 in any RD cycle moves to FILL next cycle.
REQ-024 SHALL, in FILL (exactly one cycle), drive fill_en=1, lru_update=1, fill_way/fill_addr=captured values, then return to IDLE.
REQ-025 SHALL ignore wb_done outside WB and mem_rd_done outside RD.
REQ-026 SHALL drive busy=1 iff state!=IDLE.
REQ-027 SHALL count consecutive cycles in WB or RD (counter cleared on each state entry); on count reaching TIMEOUT without done, set timeout_err=1, return to IDLE next cycle, and issue no fill.
REQ-028 SHALL keep timeout_err=1 until rst; new requests are still serviced while set.
REQ-029 SHALL give clean-miss minimum latency: capture T, RD at T+1, FILL at T+2 (if mem_rd_done at T+1), IDLE at T+3, next capture at T+3.
REQ-030 SHALL give dirty-miss minimum latency: capture T, WB T+1, RD T+2, FILL T+3, IDLE T+4.

Reset
REQ-031 SHALL, when rst=1 at a clock edge, enter IDLE and drive miss_ack, wb_req, mem_rd_req, fill_en, lru_update, busy, timeout_err=0, all address/way outputs and captured registers=0, counter=0.
REQ-032 SHALL abort any in-flight operation on rst without fill or lru_update; done inputs during or after rst are ignored until a new capture.
REQ-033 SHALL give rst priority over all other inputs in the same cycle.

Verification
REQ-034 SHALL cover clean miss: miss_req, miss_addr=0x100, victim_way=2, victim_dirty=0, mem_rd_done at T+1 -> miss_ack T+1, mem_rd_addr=0x100, fill_en+lru_update at T+2 with fill_way=2.
REQ-035 SHALL cover dirty miss: victim_valid=1, victim_dirty=1, victim_addr=0x2C0, wb_done after 3 cycles -> wb_req 3 cycles with wb_addr=0x2C0, then RD, then one-cycle FILL.
REQ-036 SHALL cover miss_req held high 5 cycles during service -> exactly one miss_ack and one fill.
REQ-037 SHALL cover TIMEOUT=4 with mem_rd_done never asserted -> timeout_err=1 after 4 RD cycles, IDLE next, no fill_en.
REQ-038 SHALL cover rst asserted in WB -> next cycle all outputs 0, state IDLE; later wb_done=1 causes no state change.
REQ-039 SHALL cover stray wb_done/mem_rd_done in IDLE and mem_rd_done in WB -> no output change.

Source files
------------

// File: rtl/lv2_miss_fill_ctrl_if.sv
// Bus bundle between the L2 pipeline / memory side and the miss-fill controller.
// The controller attaches through the slave modport; the requester/memory model uses master.
`ifndef ASSOC_LV2
`define ASSOC_LV2 8
`endif
`ifndef ASSOC_WID_LV2
`define ASSOC_WID_LV2 3
`endif

interface lv2_miss_fill_ctrl_if #(
  parameter int ADDR_WID  = 32,
  parameter int ASSOC_WID = `ASSOC_WID_LV2
);
  // Handshakes: miss_req is a level request held until the one-cycle miss_ack;
  // wb_req/mem_rd_req stay high every cycle of their phase and complete on the
  // first cycle the matching *_done is seen high (done is a one-shot "ready").
  logic                 miss_req;
  logic [ADDR_WID-1:0]  miss_addr;
  logic [ASSOC_WID-1:0] victim_way;
  logic                 victim_valid;
  logic                 victim_dirty;
  logic [ADDR_WID-1:0]  victim_addr;
  logic                 miss_ack;
  logic                 wb_req;
  logic [ADDR_WID-1:0]  wb_addr;
  logic [ASSOC_WID-1:0] wb_way;
  logic                 wb_done;
  logic                 mem_rd_req;
  logic [ADDR_WID-1:0]  mem_rd_addr;
  logic                 mem_rd_done;
  logic                 fill_en;
  logic [ASSOC_WID-1:0] fill_way;
  logic [ADDR_WID-1:0]  fill_addr;
  logic                 lru_update;
  logic                 busy;
  logic                 timeout_err;

  modport master (
    output miss_req, miss_addr, victim_way, victim_valid, victim_dirty, victim_addr,
    output wb_done, mem_rd_done,
    input  miss_ack, wb_req, wb_addr, wb_way, mem_rd_req, mem_rd_addr,
    input  fill_en, fill_way, fill_addr, lru_update, busy, timeout_err
  );

  modport slave (
    input  miss_req, miss_addr, victim_way, victim_valid, victim_dirty, victim_addr,
    input  wb_done, mem_rd_done,
    output miss_ack, wb_req, wb_addr, wb_way, mem_rd_req, mem_rd_addr,
    output fill_en, fill_way, fill_addr, lru_update, busy, timeout_err
  );
endinterface

// File: rtl/lv2_miss_fill_ctrl.sv
// L2 miss service sequencer: capture a miss, write back a dirty victim, read the
// missing block, then issue a one-cycle fill and LRU update. All outputs are flops.
`ifndef ASSOC_LV2
`define ASSOC_LV2 8
`endif
`ifndef ASSOC_WID_LV2
`define ASSOC_WID_LV2 3
`endif

module lv2_miss_fill_ctrl #(
  parameter int ASSOC     = `ASSOC_LV2,
  parameter int ASSOC_WID = `ASSOC_WID_LV2,
  parameter int ADDR_WID  = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  lv2_miss_fill_ctrl_if.slave  bus,
  output logic [1:0]           fsm_state
);

  if ((ASSOC < 1) || (ASSOC > (1 << ASSOC_WID)) || (TIMEOUT < 1) || (TIMEOUT > 255))
  begin : g_param_chk
    $error("lv2_miss_fill_ctrl: ASSOC/ASSOC_WID/TIMEOUT out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_RD   = 2'd2,
    S_FILL = 2'd3
  } state_t;

  // The counter holds the number of already-completed cycles in the current
  // WB/RD visit, so the last permitted cycle is the one where it equals TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t               state, state_nxt;
  logic [7:0]           cnt, cnt_nxt;
  logic [ADDR_WID-1:0]  cap_addr, cap_vaddr;
  logic [ASSOC_WID-1:0] cap_way;
  logic                 capture, expire;

  logic [ADDR_WID-1:0]  sel_addr, sel_vaddr;
  logic [ASSOC_WID-1:0] sel_way;
  logic                 ack_d, wb_req_d, rd_req_d, fill_d, busy_d, err_d;
  logic [ADDR_WID-1:0]  wb_addr_d, rd_addr_d, fill_addr_d;
  logic [ASSOC_WID-1:0] wb_way_d, fill_way_d;

  assign fsm_state = state;

  // State register, captured transaction and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= 8'd0;
      cap_addr        <= '0;
      cap_vaddr       <= '0;
      cap_way         <= '0;
      bus.miss_ack    <= 1'b0;
      bus.wb_req      <= 1'b0;
      bus.wb_addr     <= '0;
      bus.wb_way      <= '0;
      bus.mem_rd_req  <= 1'b0;
      bus.mem_rd_addr <= '0;
      bus.fill_en     <= 1'b0;
      bus.fill_way    <= '0;
      bus.fill_addr   <= '0;
      bus.lru_update  <= 1'b0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        cap_addr  <= bus.miss_addr;
        cap_vaddr <= bus.victim_addr;
        cap_way   <= bus.victim_way;
      end
      bus.miss_ack    <= ack_d;
      bus.wb_req      <= wb_req_d;
      bus.wb_addr     <= wb_addr_d;
      bus.wb_way      <= wb_way_d;
      bus.mem_rd_req  <= rd_req_d;
      bus.mem_rd_addr <= rd_addr_d;
      bus.fill_en     <= fill_d;
      bus.fill_way    <= fill_way_d;
      bus.fill_addr   <= fill_addr_d;
      bus.lru_update  <= fill_d;
      bus.busy        <= busy_d;
      bus.timeout_err <= err_d;
    end
  end

  // Next-state logic; a done pulse wins over expiry in the same cycle.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    expire    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.miss_req) begin
          capture   = 1'b1;
          state_nxt = (bus.victim_valid && bus.victim_dirty) ? S_WB : S_RD;
        end
      end
      S_WB: begin
        if (bus.wb_done) begin
          state_nxt = S_RD;
        end else if (cnt == CNT_LAST) begin
          expire    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_RD: begin
        if (bus.mem_rd_done) begin
          state_nxt = S_FILL;
        end else if (cnt == CNT_LAST) begin
          expire    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_FILL:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    cnt_nxt = 8'd0;
    if ((state_nxt == state) && ((state == S_WB) || (state == S_RD))) begin
      cnt_nxt = cnt + 8'd1;
    end
  end

  // Output logic: values the output flops take for the cycle being entered.
  // On the capture edge the transaction fields come straight from the inputs.
  always_comb begin
    sel_addr    = capture ? bus.miss_addr   : cap_addr;
    sel_vaddr   = capture ? bus.victim_addr : cap_vaddr;
    sel_way     = capture ? bus.victim_way  : cap_way;
    ack_d       = capture;
    wb_req_d    = (state_nxt == S_WB);
    rd_req_d    = (state_nxt == S_RD);
    fill_d      = (state_nxt == S_FILL);
    busy_d      = (state_nxt != S_IDLE);
    err_d       = bus.timeout_err | expire;
    wb_addr_d   = wb_req_d ? sel_vaddr : '0;
    wb_way_d    = wb_req_d ? sel_way   : '0;
    rd_addr_d   = rd_req_d ? sel_addr  : '0;
    fill_addr_d = fill_d   ? sel_addr  : '0;
    fill_way_d  = fill_d   ? sel_way   : '0;
  end

endmodule

// File: tb/tb_lv2_miss_fill_ctrl.sv
// Bench for lv2_miss_fill_ctrl: transaction-level reference model compared every
// cycle, a fill scoreboard, and directed scenarios with literal expectations.
module tb_lv2_miss_fill_ctrl;
  localparam int AW = 32;
  localparam int WW = 3;
  localparam int TO = 4;
  localparam int VW = 3*AW + 2*WW + 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] fsm_state;

  always #5 clk = ~clk;

  lv2_miss_fill_ctrl_if #(.ADDR_WID(AW), .ASSOC_WID(WW)) bus ();

  lv2_miss_fill_ctrl #(
    .ASSOC(8), .ASSOC_WID(WW), .ADDR_WID(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  logic [WW+AW-1:0] exp_q[$];
  logic [WW+AW-1:0] f_exp, f_act;

  // Reference model: one outstanding miss described by its phase and wait time.
  int              m_phase = 0;  // 0 none, 1 writing back, 2 reading, 3 filling
  int              m_wait  = 0;
  logic            m_ack   = 1'b0;
  logic            m_err   = 1'b0;
  logic [AW-1:0]   t_addr  = '0;
  logic [AW-1:0]   t_vaddr = '0;
  logic [WW-1:0]   t_way   = '0;

  logic [VW-1:0] dut_vec;
  assign dut_vec = {bus.miss_ack, bus.wb_req, bus.wb_addr, bus.wb_way,
                    bus.mem_rd_req, bus.mem_rd_addr,
                    bus.fill_en, bus.fill_way, bus.fill_addr,
                    bus.lru_update, bus.busy, bus.timeout_err};

  function automatic logic [VW-1:0] model_out();
    logic          in_wb, in_rd, in_fill, active;
    logic [AW-1:0] wa, ra, fa;
    logic [WW-1:0] ww, fw;
    in_wb   = (m_phase == 1);
    in_rd   = (m_phase == 2);
    in_fill = (m_phase == 3);
    active  = (m_phase != 0);
    wa = in_wb   ? t_vaddr : '0;
    ww = in_wb   ? t_way   : '0;
    ra = in_rd   ? t_addr  : '0;
    fa = in_fill ? t_addr  : '0;
    fw = in_fill ? t_way   : '0;
    return {m_ack, in_wb, wa, ww, in_rd, ra, in_fill, fw, fa, in_fill, active, m_err};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_phase = 0; m_wait = 0; m_ack = 1'b0; m_err = 1'b0;
      t_addr = '0; t_vaddr = '0; t_way = '0;
      exp_q.delete();
    end else begin
      m_ack = 1'b0;
      case (m_phase)
        0: if (bus.miss_req) begin
             t_addr  = bus.miss_addr;
             t_vaddr = bus.victim_addr;
             t_way   = bus.victim_way;
             exp_q.push_back({bus.victim_way, bus.miss_addr});
             m_ack   = 1'b1;
             m_wait  = 0;
             m_phase = (bus.victim_valid && bus.victim_dirty) ? 1 : 2;
           end
        1, 2: begin
             m_wait++;
             if ((m_phase == 1) ? bus.wb_done : bus.mem_rd_done) begin
               m_phase = m_phase + 1;
               m_wait  = 0;
             end else if (m_wait == TO) begin
               m_err   = 1'b1;
               m_phase = 0;
               void'(exp_q.pop_back());
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  // Every-cycle comparison against the model plus fill scoreboard.
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (dut_vec !== model_out()) begin
        errors++;
        $display("FAIL cycle %0d outputs act=%h exp=%h", cyc, dut_vec, model_out());
      end
      if (bus.fill_en === 1'b1) begin
        checks++;
        f_act = {bus.fill_way, bus.fill_addr};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cycle %0d fill_unexpected act=%h exp=none", cyc, f_act);
        end else begin
          f_exp = exp_q.pop_front();
          if (f_act !== f_exp) begin
            errors++;
            $display("FAIL cycle %0d fill_scoreboard act=%h exp=%h", cyc, f_act, f_exp);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.miss_req     = 1'b0;
    bus.miss_addr    = '0;
    bus.victim_way   = '0;
    bus.victim_valid = 1'b0;
    bus.victim_dirty = 1'b0;
    bus.victim_addr  = '0;
    bus.wb_done      = 1'b0;
    bus.mem_rd_done  = 1'b0;
  endtask

  task automatic set_miss(input logic [AW-1:0] addr, input logic [WW-1:0] way,
                          input logic valid, input logic dirty, input logic [AW-1:0] vaddr);
    bus.miss_req     = 1'b1;
    bus.miss_addr    = addr;
    bus.victim_way   = way;
    bus.victim_valid = valid;
    bus.victim_dirty = dirty;
    bus.victim_addr  = vaddr;
  endtask

  int acks, fills, rd_cycles, wb_cycles;

  initial begin
    idle_inputs();
    // Reset with a request and a done present: reset must dominate.
    set_miss(32'h100, 3'd1, 1'b1, 1'b1, 32'h40);
    bus.wb_done = 1'b1;
    repeat (2) step();
    chk("reset_vector", dut_vec, '0);
    chk("reset_state_busy", bus.busy, 1'b0);
    idle_inputs();
    rst    = 1'b0;
    cmp_en = 1'b1;
    step();
    chk("post_reset_ack", bus.miss_ack, 1'b0);

    // Clean miss.
    set_miss(32'h100, 3'd2, 1'b1, 1'b0, 32'h40);
    step();
    chk("clean_ack", bus.miss_ack, 1'b1);
    chk("clean_rd_req", bus.mem_rd_req, 1'b1);
    chk("clean_rd_addr", bus.mem_rd_addr, 32'h100);
    chk("clean_no_wb", bus.wb_req, 1'b0);
    bus.miss_req    = 1'b0;
    bus.mem_rd_done = 1'b1;
    step();
    chk("clean_fill_en", bus.fill_en, 1'b1);
    chk("clean_lru", bus.lru_update, 1'b1);
    chk("clean_fill_way", bus.fill_way, 3'd2);
    chk("clean_fill_addr", bus.fill_addr, 32'h100);
    bus.mem_rd_done = 1'b0;
    step();
    chk("clean_idle", bus.busy, 1'b0);

    // Dirty miss: three write-back cycles, stray mem_rd_done in the first.
    set_miss(32'h340, 3'd5, 1'b1, 1'b1, 32'h2C0);
    step();
    chk("dirty_ack", bus.miss_ack, 1'b1);
    bus.miss_req = 1'b0;
    wb_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      wb_cycles += int'(bus.wb_req);
      chk("dirty_wb_addr", bus.wb_addr, 32'h2C0);
      chk("dirty_wb_way", bus.wb_way, 3'd5);
      chk("dirty_no_rd_in_wb", bus.mem_rd_req, 1'b0);
      bus.mem_rd_done = (i == 0);
      bus.wb_done     = (i == 2);
      step();
    end
    chk("dirty_wb_cycles", wb_cycles, 3);
    chk("dirty_rd_req", bus.mem_rd_req, 1'b1);
    chk("dirty_rd_addr", bus.mem_rd_addr, 32'h340);
    chk("dirty_wb_dropped", bus.wb_req, 1'b0);
    bus.wb_done     = 1'b0;
    bus.mem_rd_done = 1'b1;
    step();
    chk("dirty_fill_en", bus.fill_en, 1'b1);
    chk("dirty_fill_way", bus.fill_way, 3'd5);
    chk("dirty_fill_addr", bus.fill_addr, 32'h340);
    bus.mem_rd_done = 1'b0;
    step();
    chk("dirty_idle", bus.busy, 1'b0);

    // Request held five cycles; done arrives on the last permitted RD cycle.
    acks = 0; fills = 0;
    set_miss(32'h500, 3'd1, 1'b0, 1'b1, 32'h1000);
    for (int i = 0; i < 10; i++) begin
      step();
      acks  += int'(bus.miss_ack);
      fills += int'(bus.fill_en);
      if (i == 3) begin
        bus.miss_req    = 1'b0;
        bus.mem_rd_done = 1'b1;
      end
      if (i == 4) bus.mem_rd_done = 1'b0;
    end
    chk("held_one_ack", acks, 1);
    chk("held_one_fill", fills, 1);
    chk("held_no_timeout", bus.timeout_err, 1'b0);

    // Timeout in RD.
    set_miss(32'h600, 3'd4, 1'b1, 1'b0, 32'h0);
    step();
    bus.miss_req = 1'b0;
    rd_cycles = 0; fills = 0;
    for (int i = 0; i < 4; i++) begin
      rd_cycles += int'(bus.mem_rd_req);
      fills     += int'(bus.fill_en);
      step();
    end
    chk("timeout_rd_cycles", rd_cycles, 4);
    chk("timeout_err_set", bus.timeout_err, 1'b1);
    chk("timeout_idle", bus.busy, 1'b0);
    chk("timeout_no_fill", bus.fill_en, 1'b0);
    bus.mem_rd_done = 1'b1;
    step();
    chk("timeout_late_done", bus.busy, 1'b0);
    chk("timeout_sticky", bus.timeout_err, 1'b1);
    bus.mem_rd_done = 1'b0;
    chk("timeout_fill_count", fills, 0);

    // Service continues with the error set; back-to-back clean misses.
    set_miss(32'h800, 3'd3, 1'b0, 1'b0, 32'h0);
    bus.mem_rd_done = 1'b1;
    step();
    chk("b2b_ack1", bus.miss_ack, 1'b1);
    step();
    chk("b2b_fill1", bus.fill_addr, 32'h800);
    chk("b2b_err_kept", bus.timeout_err, 1'b1);
    step();
    chk("b2b_idle_t3", bus.busy, 1'b0);
    set_miss(32'h900, 3'd7, 1'b0, 1'b0, 32'h0);
    step();
    chk("b2b_ack2", bus.miss_ack, 1'b1);
    chk("b2b_rd_addr2", bus.mem_rd_addr, 32'h900);
    bus.miss_req = 1'b0;
    step();
    chk("b2b_fill2_way", bus.fill_way, 3'd7);
    bus.mem_rd_done = 1'b0;
    step();

    // Reset in the middle of a write-back.
    set_miss(32'hA00, 3'd0, 1'b1, 1'b1, 32'hB40);
    step();
    chk("rstwb_wb_req", bus.wb_req, 1'b1);
    bus.miss_req = 1'b0;
    step();
    rst         = 1'b1;
    bus.wb_done = 1'b1;
    step();
    chk("rstwb_vector", dut_vec, '0);
    rst             = 1'b0;
    bus.mem_rd_done = 1'b1;
    fills = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      fills += int'(bus.fill_en) + int'(bus.busy);
    end
    chk("rstwb_no_activity", fills, 0);

    // Stray dones while idle.
    for (int i = 0; i < 2; i++) step();
    chk("stray_idle_vector", dut_vec, '0);
    idle_inputs();
    step();
    chk("queue_empty", exp_q.size(), 0);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
